mlsib_key_checker: RTL and testbench

//  Key-check TDR sitting upstream of the locking SIB: drives its CompOut input.

---
 rtl/mlsib_pkg.sv | 19 +
 rtl/mlsib_key_checker_key_shift_reg.sv | 31 +++
 rtl/mlsib_key_checker.sv | 105 ++++++++++
 tb/tb_mlsib_key_checker.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mlsib_pkg.sv
// Shared definitions for the MLSIB key-check slice: the key-checker state
// encoding and the default secret key used when no override is supplied.
package mlsib_pkg;

   // Key checker FSM: normal operation or permanent lockout until reset
   typedef enum logic {
      KC_OPEN    = 1'b0,
      KC_LOCKOUT = 1'b1
   } kc_state_t;

   // Default secret key; must be nonzero so an all-zero register never matches
   localparam logic [15:0] MLSIB_DEFAULT_KEY = 16'hA5C3;

   // Width needed to hold a failure count from 0 up to and including max_tries
   function automatic int kc_cnt_width(input int max_tries);
      return (max_tries < 1) ? 1 : $clog2(max_tries + 1);
   endfunction

endpackage

// File: rtl/mlsib_key_checker_key_shift_reg.sv
// Key shift/capture register for the key checker. Bits enter at the MSB from
// SI and leave at the LSB on SO. A capture load takes precedence over a shift,
// and both only act while the segment is selected.
module key_shift_reg #(
   parameter int WIDTH = 16
) (
   input  logic             Clock,
   input  logic             Rst,
   input  logic             select,
   input  logic             shift_en,
   input  logic             capture_en,
   input  logic             si,
   input  logic [WIDTH-1:0] capture_value,
   output logic [WIDTH-1:0] sh_reg,
   output logic             so
);

   // Capture load wins over shifting; without select the register holds
   always_ff @(posedge Clock or posedge Rst) begin
      if (Rst) begin
         sh_reg <= '0;
      end else if (select && capture_en) begin
         sh_reg <= capture_value;
      end else if (select && shift_en) begin
         sh_reg <= {si, sh_reg[WIDTH-1:1]};
      end
   end

   assign so = sh_reg[0];

endmodule

// File: rtl/mlsib_key_checker.sv
// Key-check TDR placed upstream of the locking SIB. A key is shifted in on the
// scan path and compared combinationally against a fixed secret; CompOut tells
// the SIB whether an open may proceed. Failed open attempts are counted and,
// after MAX_TRIES failures, the checker locks out until Rst.
// Optional build macro: MLSIB_KEYCHK_STATUS_CAPTURE_EN makes a capture load
// {Locked, FailCount} into the low register bits so status can be scanned out;
// without it a capture clears the register. The key itself is never captured.
module mlsib_key_checker
   import mlsib_pkg::*;
#(
   parameter  int                   KEY_WIDTH = 16,
   parameter  logic [KEY_WIDTH-1:0] KEY_VALUE = KEY_WIDTH'(MLSIB_DEFAULT_KEY),
   parameter  int                   MAX_TRIES = 3,
   localparam int                   CNT_WIDTH = kc_cnt_width(MAX_TRIES)
) (
   input  logic                 Clock,
   input  logic                 Rst,
   input  logic                 SI,
   input  logic                 ShiftEN,
   input  logic                 CaptureEN,
   input  logic                 UpdateEn,
   input  logic                 Select,
   input  logic                 OpenReq,
   output logic                 SO,
   output logic                 CompOut,
   output logic                 Locked,
   output logic [CNT_WIDTH-1:0] FailCount
);

   localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_TRIES);

   kc_state_t              state;
   logic [KEY_WIDTH-1:0]   sh_reg;
   logic [KEY_WIDTH-1:0]   capture_value;
   logic [CNT_WIDTH-1:0]   fail_count;
   logic [CNT_WIDTH-1:0]   fail_next;
   logic                   upd_dly;
   logic                   upd_pulse;
   logic                   match;
   logic                   locked_int;

   key_shift_reg #(
      .WIDTH (KEY_WIDTH)
   ) u_key_shift_reg (
      .Clock         (Clock),
      .Rst           (Rst),
      .select        (Select),
      .shift_en      (ShiftEN),
      .capture_en    (CaptureEN),
      .si            (SI),
      .capture_value (capture_value),
      .sh_reg        (sh_reg),
      .so            (SO)
   );

   // Capture source: status word when enabled, otherwise all zeros
   always_comb begin
      capture_value = '0;
`ifdef MLSIB_KEYCHK_STATUS_CAPTURE_EN
      capture_value[CNT_WIDTH:0] = {locked_int, fail_count};
`endif
   end

   assign match      = (sh_reg == KEY_VALUE);
   assign locked_int = (state == KC_LOCKOUT);
   assign upd_pulse  = Select & UpdateEn & ~upd_dly;
   assign fail_next  = fail_count + CNT_WIDTH'(1);

   assign CompOut   = match & (state == KC_OPEN);
   assign Locked    = locked_int;
   assign FailCount = fail_count;

   // Attempt FSM: a held UpdateEn counts once; only opens affect the count,
   // and the count saturates because lockout freezes it at MAX_TRIES
   always_ff @(posedge Clock or posedge Rst) begin
      if (Rst) begin
         state      <= KC_OPEN;
         fail_count <= '0;
         upd_dly    <= 1'b0;
      end else begin
         upd_dly <= Select & UpdateEn;
         if (upd_pulse && OpenReq) begin
            case (state)
               KC_OPEN: begin
                  if (match) begin
                     fail_count <= '0;
                  end else begin
                     fail_count <= fail_next;
                     if (fail_next == MAX_CNT) begin
                        state <= KC_LOCKOUT;
                     end
                  end
               end
               KC_LOCKOUT: begin
                  fail_count <= MAX_CNT;
               end
               default: begin
                  state <= KC_OPEN;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mlsib_key_checker.sv
// Directed self-checking bench for mlsib_key_checker with the default
// parameters (16-bit key 16'hA5C3, three tries, 2-bit failure count).
module tb_mlsib_key_checker;

   logic       Clock;
   logic       Rst;
   logic       SI;
   logic       ShiftEN;
   logic       CaptureEN;
   logic       UpdateEn;
   logic       Select;
   logic       OpenReq;
   logic       SO;
   logic       CompOut;
   logic       Locked;
   logic [1:0] FailCount;

   int total;
   int bad;

   localparam logic [15:0] GOOD_KEY = 16'hA5C3;

   mlsib_key_checker dut (
      .Clock     (Clock),
      .Rst       (Rst),
      .SI        (SI),
      .ShiftEN   (ShiftEN),
      .CaptureEN (CaptureEN),
      .UpdateEn  (UpdateEn),
      .Select    (Select),
      .OpenReq   (OpenReq),
      .SO        (SO),
      .CompOut   (CompOut),
      .Locked    (Locked),
      .FailCount (FailCount)
   );

   // Free-running scan clock, 10 time-unit period
   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   // Overall time limit so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic applyStimulus(input logic sel, input logic sh, input logic cap,
                                input logic upd, input logic open, input logic si);
      Select    = sel;
      ShiftEN   = sh;
      CaptureEN = cap;
      UpdateEn  = upd;
      OpenReq   = open;
      SI        = si;
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(negedge Clock);
   endtask

   // Shift a full key in, LSB first, then go idle
   task automatic shiftKey(input logic [15:0] key);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, key[i]);
         tick();
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
   endtask

   // Hold UpdateEn for n cycles, then release and let the edge detector clear
   task automatic updatePulse(input logic open, input int n);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, open, 1'b0);
      repeat (n) tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
   endtask

   logic [15:0] scanned;
   logic [15:0] cap_expect;

   initial begin
      total = 0;
      bad   = 0;
      Rst   = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      checkOutput("reset_so", 16'(SO), 16'h0);
      checkOutput("reset_compout", 16'(CompOut), 16'h0);
      checkOutput("reset_locked", 16'(Locked), 16'h0);
      checkOutput("reset_failcount", 16'(FailCount), 16'h0);
      Rst = 1'b0;
      tick();

      // Correct key opens, count stays at zero
      shiftKey(GOOD_KEY);
      checkOutput("key_so_lsb", 16'(SO), 16'h1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      #1;
      checkOutput("open_compout_same_cycle", 16'(CompOut), 16'h1);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("open_failcount", 16'(FailCount), 16'h0);
      checkOutput("open_locked", 16'(Locked), 16'h0);

      // Three wrong opens lead to lockout
      shiftKey(16'h0000);
      checkOutput("wrong_compout", 16'(CompOut), 16'h0);
      for (int k = 1; k <= 3; k++) begin
         updatePulse(1'b1, 1);
         checkOutput($sformatf("fail_count_%0d", k), 16'(FailCount), 16'(k));
         checkOutput($sformatf("fail_locked_%0d", k), 16'(Locked), (k == 3) ? 16'h1 : 16'h0);
      end

      // Lockout masks the correct key and freezes the count
      shiftKey(GOOD_KEY);
      checkOutput("lockout_compout", 16'(CompOut), 16'h0);
      updatePulse(1'b1, 1);
      checkOutput("lockout_saturate", 16'(FailCount), 16'h3);
      checkOutput("lockout_still_locked", 16'(Locked), 16'h1);
      #2;
      Rst = 1'b1;
      #1;
      checkOutput("rst_clears_locked", 16'(Locked), 16'h0);
      checkOutput("rst_clears_count", 16'(FailCount), 16'h0);
      tick();
      Rst = 1'b0;
      tick();
      shiftKey(GOOD_KEY);
      checkOutput("after_rst_compout", 16'(CompOut), 16'h1);

      // A held UpdateEn counts only once
      shiftKey(16'h1234);
      updatePulse(1'b1, 4);
      checkOutput("held_update_once", 16'(FailCount), 16'h1);

      // Close requests and deselected updates do not count
      updatePulse(1'b0, 1);
      updatePulse(1'b0, 2);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("no_count_close_or_desel", 16'(FailCount), 16'h1);

      // Deselected shifting leaves the register alone
      shiftKey(GOOD_KEY);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (4) tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      checkOutput("desel_shift_compout", 16'(CompOut), 16'h1);
      checkOutput("desel_shift_so", 16'(SO), 16'h1);

      // Bring the count to two, then capture with shift also asserted
      shiftKey(16'h0000);
      updatePulse(1'b1, 1);
      checkOutput("count_before_capture", 16'(FailCount), 16'h2);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      scanned = '0;
      for (int i = 0; i < 16; i++) begin
         scanned[i] = SO;
         applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         tick();
      end
`ifdef MLSIB_KEYCHK_STATUS_CAPTURE_EN
      cap_expect = 16'h0002;
`else
      cap_expect = 16'h0000;
`endif
      checkOutput("capture_value", scanned, cap_expect);

      // Reset in the middle of a shift clears SO immediately
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
         tick();
      end
      checkOutput("ones_so", 16'(SO), 16'h1);
      #2;
      Rst = 1'b1;
      #1;
      checkOutput("midshift_rst_so", 16'(SO), 16'h0);
      checkOutput("midshift_rst_count", 16'(FailCount), 16'h0);
      tick();
      Rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
